// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver with a 2-bit saturating-counter pattern history
// table for fetch prediction and a {V,N,Z} status register for flag-based branches.
module branch_resolve_unit #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int PHT_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  input  logic              flags_we,
  input  logic [2:0]        flags_in,
  output logic [2:0]        status,
  output logic [2:0]        selectmux,
  output logic              link_we,
  output logic              flush
);

  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BNE   = 4'd2;
  localparam logic [3:0] OP_BLEZ  = 4'd3;
  localparam logic [3:0] OP_BMV   = 4'd4;
  localparam logic [3:0] OP_BALN  = 4'd5;
  localparam logic [3:0] OP_BALRN = 4'd6;
  localparam logic [3:0] OP_JALPC = 4'd7;
  localparam logic [3:0] OP_BNEAL = 4'd8;

  localparam int PHT_DEPTH = 1 << PHT_BITS;

  logic [1:0]          pht_q [PHT_DEPTH];
  logic [1:0]          pht_d;
  logic [2:0]          status_q;
  logic [2:0]          selectmux_q;
  logic                link_we_q;
  logic                flush_q;

  logic [PHT_BITS-1:0] fetch_idx;
  logic [PHT_BITS-1:0] ex_idx;
  logic                eq;
  logic                lez;
  logic                taken;
  logic                predicted;
  logic                link_op;
  logic [2:0]          sel_hit;
  logic [2:0]          selectmux_d;
  logic                link_we_d;
  logic                flush_d;
  logic                resolve;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:PHT_BITS+2], fetch_pc[1:0],
                            ex_pc[PC_W-1:PHT_BITS+2], ex_pc[1:0]};

  assign fetch_idx = fetch_pc[PHT_BITS+1:2];
  assign ex_idx    = ex_pc[PHT_BITS+1:2];
  assign resolve   = ex_valid && !stall;

  // Reading the registered counter gives the pre-update value on a same-index hit.
  assign pred_taken = pht_q[fetch_idx][1];

  assign eq  = (dataa == datab);
  assign lez = dataa[DATA_W-1] | (dataa == '0);

  always_comb begin
    taken     = 1'b0;
    predicted = 1'b0;
    link_op   = 1'b0;
    sel_hit   = 3'b000;
    case (ex_op)
      OP_BEQ:   begin taken = eq;          predicted = 1'b1; sel_hit = 3'b001; end
      OP_BNE:   begin taken = !eq;         predicted = 1'b1; sel_hit = 3'b001; end
      OP_BLEZ:  begin taken = lez;         predicted = 1'b1; sel_hit = 3'b001; end
      OP_BMV:   begin taken = status_q[2];                   sel_hit = 3'b010; end
      OP_BALN:  begin taken = status_q[1]; link_op = 1'b1;   sel_hit = 3'b011; end
      OP_BALRN: begin taken = status_q[1]; link_op = 1'b1;   sel_hit = 3'b100; end
      OP_JALPC: begin taken = 1'b1;        link_op = 1'b1;   sel_hit = 3'b001; end
      OP_BNEAL: begin taken = !eq; predicted = 1'b1; link_op = 1'b1; sel_hit = 3'b001; end
      default:  ;
    endcase
    selectmux_d = taken ? sel_hit : 3'b000;
    link_we_d   = taken & link_op;
    flush_d     = predicted ? (taken ^ ex_pred) : taken;
  end

  always_comb begin
    pht_d = pht_q[ex_idx];
    if (taken && pht_q[ex_idx] != 2'b11)
      pht_d = pht_q[ex_idx] + 2'b01;
    else if (!taken && pht_q[ex_idx] != 2'b00)
      pht_d = pht_q[ex_idx] - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selectmux_q <= 3'b000;
      link_we_q   <= 1'b0;
      flush_q     <= 1'b0;
      status_q    <= 3'b000;
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
    end else begin
      if (resolve) begin
        selectmux_q <= selectmux_d;
        link_we_q   <= link_we_d;
        flush_q     <= flush_d;
      end else begin
        selectmux_q <= 3'b000;
        link_we_q   <= 1'b0;
        flush_q     <= 1'b0;
      end
      if (flags_we && !stall) status_q <= flags_in;
      if (resolve && predicted) pht_q[ex_idx] <= pht_d;
    end
  end

  assign status    = status_q;
  assign selectmux = selectmux_q;
  assign link_we   = link_we_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit: the driver queues the expected
// registered response of each edge, a monitor pops and compares after the edge.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_pc;
  logic        ex_pred;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        flags_we;
  logic [2:0]  flags_in;
  logic [2:0]  status;
  logic [2:0]  selectmux;
  logic        link_we;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .PHT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_op(ex_op), .ex_pc(ex_pc),
    .ex_pred(ex_pred), .dataa(dataa), .datab(datab), .flags_we(flags_we),
    .flags_in(flags_in), .status(status), .selectmux(selectmux),
    .link_we(link_we), .flush(flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected {selectmux,link_we,flush} per issued edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {27'd0, selectmux, link_we, flush}, {27'd0, e.exp});
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic pr,
                       input logic st, input logic fwe, input logic [2:0] fin);
    ex_valid = v; ex_op = op; ex_pc = pc; dataa = a; datab = b;
    ex_pred = pr; stall = st; flags_we = fwe; flags_in = fin;
  endtask

  task automatic issue(input string name, input logic [2:0] es, input logic el, input logic ef);
    exp_t e;
    e.name = name;
    e.exp  = {es, el, ef};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step(input string name, input logic [3:0] op, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic pr,
                      input logic [2:0] es, input logic el, input logic ef);
    drive(1'b1, op, pc, a, b, pr, 1'b0, 1'b0, 3'b000);
    issue(name, es, el, ef);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    fetch_pc = 32'h40;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
    #12;
    check("reset_sel", {29'd0, selectmux}, 32'd0);
    check("reset_link_flush", {30'd0, link_we, flush}, 32'd0);
    check("reset_status", {29'd0, status}, 32'd0);
    check("reset_pred", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ at 0x40, predicted not-taken but taken: flush; counter 01 -> 10.
    drive(1'b1, 4'd1, 32'h40, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 3'b000);
    check("pred_same_cycle_pre_update", {31'd0, pred_taken}, 32'd0);
    issue("beq_taken", 3'b001, 1'b0, 1'b1);
    check("pred_after_beq", {31'd0, pred_taken}, 32'd1);

    step("blez_neg", 4'd3, 32'h44, 32'h8000_0000, 32'd0, 1'b1, 3'b001, 1'b0, 1'b0);
    step("blez_pos", 4'd3, 32'h44, 32'd1, 32'd0, 1'b1, 3'b000, 1'b0, 1'b1);
    step("blez_zero", 4'd3, 32'h48, 32'd0, 32'd7, 1'b0, 3'b001, 1'b0, 1'b1);

    // Flag write and BALN in one cycle: branch sees the old status.
    drive(1'b1, 4'd5, 32'h60, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    issue("baln_old_status", 3'b000, 1'b0, 1'b0);
    check("status_after_write", {29'd0, status}, 32'd2);
    step("baln_taken", 4'd5, 32'h60, 32'd0, 32'd0, 1'b0, 3'b011, 1'b1, 1'b1);
    step("balrn_taken", 4'd6, 32'h64, 32'd0, 32'd0, 1'b0, 3'b100, 1'b1, 1'b1);
    step("bmv_not_taken", 4'd4, 32'h68, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'h68, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3'b100);
    issue("flags_only", 3'b000, 1'b0, 1'b0);
    step("bmv_taken", 4'd4, 32'h68, 32'd0, 32'd0, 1'b0, 3'b010, 1'b0, 1'b1);
    step("jalpc", 4'd7, 32'h6c, 32'd0, 32'd0, 1'b0, 3'b001, 1'b1, 1'b1);
    step("bneal_taken", 4'd8, 32'h4c, 32'd1, 32'd2, 1'b0, 3'b001, 1'b1, 1'b1);
    step("bneal_not_taken", 4'd8, 32'h4c, 32'd3, 32'd3, 1'b1, 3'b000, 1'b0, 1'b1);
    step("op_reserved", 4'd9, 32'h4c, 32'd3, 32'd3, 1'b1, 3'b000, 1'b0, 1'b0);

    // Saturation at index 4 (pc 0x50).
    fetch_pc = 32'h50;
    for (int i = 0; i < 4; i++) begin
      step("bne_taken", 4'd2, 32'h50, 32'd1, 32'd2, 1'b1, 3'b001, 1'b0, 1'b0);
      check("pred_sat_up", {31'd0, pred_taken}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step("bne_not_taken", 4'd2, 32'h50, 32'd9, 32'd9, 1'b0, 3'b000, 1'b0, 1'b0);
      check("pred_sat_down", {31'd0, pred_taken}, (i == 0) ? 32'd1 : 32'd0);
    end
    step("bne_from_zero", 4'd2, 32'h50, 32'd1, 32'd2, 1'b0, 3'b001, 1'b0, 1'b1);
    check("pred_no_wrap_01", {31'd0, pred_taken}, 32'd0);
    step("bne_to_two", 4'd2, 32'h50, 32'd1, 32'd2, 1'b1, 3'b001, 1'b0, 1'b0);
    check("pred_no_wrap_10", {31'd0, pred_taken}, 32'd1);

    // Invalid instruction and stall: no outputs, no state change.
    fetch_pc = 32'h40;
    drive(1'b0, 4'd2, 32'h40, 32'd4, 32'd4, 1'b1, 1'b0, 1'b0, 3'b000);
    issue("not_valid", 3'b000, 1'b0, 1'b0);
    check("pred_not_valid_hold", {31'd0, pred_taken}, 32'd1);
    drive(1'b1, 4'd7, 32'h40, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 3'b111);
    issue("stall_jalpc", 3'b000, 1'b0, 1'b0);
    check("status_stall_hold", {29'd0, status}, 32'd4);
    drive(1'b1, 4'd2, 32'h40, 32'd4, 32'd4, 1'b1, 1'b1, 1'b0, 3'b000);
    issue("stall_bne", 3'b000, 1'b0, 1'b0);
    check("pred_stall_hold", {31'd0, pred_taken}, 32'd1);

    // Asynchronous reset between edges while outputs are active.
    step("jalpc_pre_reset", 4'd7, 32'h6c, 32'd0, 32'd0, 1'b0, 3'b001, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", {29'd0, selectmux}, 32'd0);
    check("async_rst_link_flush", {30'd0, link_we, flush}, 32'd0);
    check("async_rst_status", {29'd0, status}, 32'd0);
    check("async_rst_pred", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step("beq_after_reset", 4'd1, 32'h40, 32'd7, 32'd7, 1'b1, 3'b001, 1'b0, 1'b0);
    check("pred_after_reset_beq", {31'd0, pred_taken}, 32'd1);
    drive(1'b0, 4'd0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width for compare.
REQ-002 SHALL have parameter PC_W, default 32, program counter width.
REQ-003 SHALL have parameter PHT_BITS, default 4, log2 of pattern-history-table depth.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  in  1  freezes all state updates.
REQ-007 SHALL have port fetch_pc  in  PC_W  fetch-stage PC for prediction lookup.
REQ-008 SHALL have port pred_taken  out  1  fetch prediction, combinational.
REQ-009 SHALL have port ex_valid  in  1  execute-stage instruction valid.
REQ-010 SHALL have port ex_op  in  4  branch op: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BMV, 5 BALN, 6 BALRN, 7 JALPC, 8 BNEAL; 9-15 treated as none.
REQ-011 SHALL have port ex_pc  in  PC_W  PC of execute-stage instruction.
REQ-012 SHALL have port ex_pred  in  1  prediction carried with that instruction.
REQ-013 SHALL have ports dataa, datab  in  DATA_W  compare operands.
REQ-014 SHALL have ports flags_we  in  1, flags_in  in  3  status write {V,N,Z}.
REQ-015 SHALL have port status  out  3  status register {V,N,Z}.
REQ-016 SHALL have port selectmux  out  3  registered next-PC select.
REQ-017 SHALL have ports link_we  out  1, flush  out  1  registered link write and pipeline flush.

Function
REQ-018 SHALL compute eq = (dataa == datab) and lez = dataa[DATA_W-1] | (dataa == 0), full width.
REQ-019 SHALL evaluate taken per op: BEQ eq; BNE !eq; BLEZ lez; BMV status[2]; BALN status[1]; BALRN status[1]; JALPC 1; BNEAL !eq; none 0.
REQ-020 SHALL encode the next-PC select: 001 target (BEQ, BNE, BLEZ, JALPC, BNEAL), 010 memory target (BMV), 011 register target (BALN), 100 register target (BALRN), 000 when not taken.
REQ-021 SHALL register selectmux, link_we and flush on the edge where ex_valid=1 and stall=0, giving latency 1 cycle; all three SHALL be 0 on every other edge.
REQ-022 SHALL assert link_we for taken BALN, BALRN, BNEAL and for JALPC.
REQ-023 SHALL treat BEQ, BNE, BLEZ and BNEAL as predicted ops, with flush = taken XOR ex_pred.
REQ-024 SHALL treat BMV, BALN, BALRN and JALPC as unpredicted ops, with flush = taken.
REQ-025 SHALL hold 2^PHT_BITS 2-bit saturating counters, indexed by pc[PHT_BITS+1:2].
REQ-026 SHALL drive pred_taken = counter[fetch index][1].
REQ-027 SHALL update the counter at ex_pc index only for predicted ops with ex_valid=1 and stall=0: increment toward 11 if taken, decrement toward 00 if not; no wrap.
REQ-028 SHALL return the pre-update counter value when fetch and update hit the same index in one cycle.
REQ-029 SHALL load status from flags_in when flags_we=1 and stall=0.
REQ-030 SHALL evaluate a branch in the same cycle as flags_we against the old status value.
REQ-031 SHALL hold the status register and PHT during stall=1, and force the registered outputs to 0.

Reset
REQ-032 SHALL, on rst_n=0 at any time (including mid-resolve), immediately clear selectmux, link_we, flush and status to 0 and set every PHT counter to 01, without waiting for clk.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst_n returns to 1.

Verification
REQ-034 SHALL cover: after reset, BEQ at pc 0x40 with dataa=datab=5 and ex_pred=0 -> next cycle selectmux=001, flush=1, link_we=0; counter[0] goes 01->10, and pred_taken=1 at fetch_pc 0x40.
REQ-035 SHALL cover: BLEZ with dataa=0x80000000 taken, then with dataa=1 not taken -> selectmux=001 then 000.
REQ-036 SHALL cover: flags_we=1 with flags_in=010 and BALN in the same cycle -> old status (000) is used, selectmux=000; BALN next cycle -> 011, link_we=1, flush=1.
REQ-037 SHALL cover: four taken BNE at one index -> counter saturates at 11; four not-taken -> saturates at 00, no wrap.
REQ-038 SHALL cover: stall=1 with valid JALPC -> outputs 0 and PHT/status unchanged; rst_n low mid-cycle -> outputs 0 immediately.
